host_spi_cmd_seq: RTL and testbench
===================================

# host_spi_cmd_seq

Host-side command sequencer that sits directly upstream of `host_spi` on the FPGA clock domain. It accepts register read/write commands over a valid/ready interface, buffers them in a small FIFO, and formats each one into a `host_spi` frame. It then drives the `spi_start`/`spi_complete`/`spi_rx_valid` handshake and returns read data on a valid/ready response port. A watchdog bounds every transaction so a hung SPI link cannot stall the host.

## Interface
Parameters:
- `DATA_W`, default 18: register data width; must equal `host_spi` RX width.
- `ADDR_W`, default 8: register address width.
- `DEPTH`, default 4: command FIFO depth, power of 2, ≥2.
- `TIMEOUT_CYC`, default 1024: maximum cycles spent waiting for `host_spi` completion.
- `GAP_CYC`, default 2: idle cycles enforced between frames, ≥1.

Ports:
- `clk`, in, 1: FPGA clock; the block uses this one clock only.
- `rst`, in, 1: asynchronous, active-high reset.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: equals `!fifo_full`.
- `cmd_write`, in, 1: 1 selects write, 0 selects read.
- `cmd_addr`, in, `ADDR_W`: register address.
- `cmd_wdata`, in, `DATA_W`: write data; ignored for reads.
- `rsp_valid`, out, 1: read response available.
- `rsp_ready`, in, 1: response consumed.
- `rsp_addr`, out, `ADDR_W`: address of the read.
- `rsp_rdata`, out, `DATA_W`: read data.
- `rsp_err`, out, 1: read timed out; `rsp_rdata` is 0 in that case.
- `spi_start`, out, 1: one-cycle start pulse to `host_spi`.
- `spi_tx_data`, out, `DATA_W+ADDR_W+3`: frame sent to `host_spi`.
- `spi_complete`, in, 1: `host_spi` frame finished.
- `spi_rx_data`, in, `DATA_W`: `host_spi` read data.
- `spi_rx_valid`, in, 1: `spi_rx_data` is valid.
- `busy`, out, 1: high whenever the state is not IDLE or the FIFO is non-empty.
- `err_timeout`, out, 1: sticky timeout flag; cleared only by `rst`.
- `fifo_level`, out, `$clog2(DEPTH)+1`: number of queued commands.

## Operation
- Frame format: `{op[1:0], addr, 1'b0, data}`.
  - Write: `op=2'b10`, data field = `cmd_wdata`.
  - Read: `op=2'b01`, data field = 0.
- FIFO behaviour:
  - Push on `cmd_valid & cmd_ready`. Pop happens only on the IDLE→LAUNCH transition.
  - Full: `cmd_ready=0`. Empty: the sequencer stays in IDLE. There is no bypass path.
  - Read and write pointers wrap modulo `DEPTH`.
- FSM states: IDLE, LAUNCH, WAIT_WR, WAIT_RD, RESP, GAP.
  - IDLE: if the FIFO is non-empty, pop, register the frame into `spi_tx_data`, go to LAUNCH.
  - LAUNCH: `spi_start=1` for exactly this cycle. Go to WAIT_WR (write) or WAIT_RD (read). Clear the watchdog.
  - WAIT_WR: on `spi_complete`, go to GAP. Ignore `spi_rx_valid`.
  - WAIT_RD: on `spi_rx_valid`, capture `spi_rx_data` into `rsp_rdata`, set `rsp_err=0`, go to RESP. Ignore `spi_complete`.
  - Watchdog, both wait states: it counts cycles in the wait state. When the count reaches `TIMEOUT_CYC` with no completion, set `err_timeout`.
    - Write: go to GAP.
    - Read: set `rsp_rdata=0`, `rsp_err=1`, go to RESP.
  - RESP: hold `rsp_valid=1` with stable `rsp_*` until `rsp_ready`, then go to GAP.
  - GAP: count `GAP_CYC` cycles, then go to IDLE.
- `spi_tx_data` holds its value from LAUNCH until the next IDLE pop.
- Completion and timeout in the same cycle: completion wins and `err_timeout` is not set.
- `spi_complete`/`spi_rx_valid` arriving in IDLE, LAUNCH, RESP or GAP are ignored.
- Commands may be pushed in any state, including during RESP stall.

## Timing
- Reset values: `spi_start=0`, `spi_tx_data=0`, `rsp_valid=0`, `rsp_addr=0`, `rsp_rdata=0`, `rsp_err=0`, `busy=0`, `err_timeout=0`, `fifo_level=0`, `cmd_ready=1`, state IDLE.
- Reset mid-operation: the FIFO is flushed, any in-flight transaction is abandoned, and no response is produced. `host_spi` shares `rst`.
- Launch latency: a command accepted at edge N into an empty, idle block produces `spi_start` high during cycle N+1 to N+2.
- Read response: `rsp_valid` rises on the edge after the `spi_rx_valid` cycle.
- Back-to-back frames: after completion, the next `spi_start` comes no earlier than `GAP_CYC+2` cycles later.
- All outputs are registered except `cmd_ready` and `busy`.

## Test plan
- Write `addr=0`, `wdata=18'h10101` → one `spi_start` pulse with `spi_tx_data={2'b10,8'h00,1'b0,18'h10101}`; after `spi_complete`, no `rsp_valid`; `busy` returns to 0.
- Read `addr=3`, model returns `18'h2ABCD` → frame `{2'b01,8'h03,1'b0,18'h0}`; then `rsp_valid` with `rsp_addr=3`, `rsp_rdata=18'h2ABCD`, `rsp_err=0`; hold `rsp_ready=0` for 10 cycles and check the response stays stable and no new `spi_start` is issued.
- Push 5 commands with `DEPTH=4` while the link is stalled → `cmd_ready=0` once `fifo_level=4`; the 5th command is accepted after the first pop; all frames are issued in order with ≥`GAP_CYC` idle cycles between them.
- Read with no `spi_rx_valid`, `TIMEOUT_CYC=16` → at 16 wait cycles: `rsp_valid`, `rsp_err=1`, `rsp_rdata=0`, `err_timeout=1` (sticky); the next queued write then proceeds normally.
- `spi_complete` coincident with the timeout terminal count → `err_timeout` stays 0. A stray `spi_complete` in IDLE → no state change.
- Assert `rst` during WAIT_RD with 2 commands queued → all outputs go to reset values, `fifo_level=0`, and no response appears after reset is released.

Source files
------------

// File: rtl/host_spi_cmd_seq_if.sv
// host_spi_cmd_seq_if
// Bundles the command, response and host_spi-facing signals of the command
// sequencer.
//   slave  : the sequencer itself (takes commands, returns responses,
//            drives the host_spi start/frame).
//   master : everything around it (the host issuing commands and the
//            host_spi engine reporting completion and read data).
//
// Handshake rule (cmd_* and rsp_*): a transfer happens on a rising clk edge
// where valid and ready are both high. A source that raises valid keeps it
// and its payload stable until that edge. Ready may depend on nothing but
// the receiver's own state; it never waits for valid.
interface host_spi_cmd_seq_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 8
);
  // Command channel
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_write;
  logic [ADDR_W-1:0]        cmd_addr;
  logic [DATA_W-1:0]        cmd_wdata;
  // Read response channel
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ADDR_W-1:0]        rsp_addr;
  logic [DATA_W-1:0]        rsp_rdata;
  logic                     rsp_err;
  // host_spi side
  logic                     spi_start;
  logic [DATA_W+ADDR_W+2:0] spi_tx_data;
  logic                     spi_complete;
  logic [DATA_W-1:0]        spi_rx_data;
  logic                     spi_rx_valid;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           spi_complete, spi_rx_data, spi_rx_valid,
    output cmd_ready, rsp_valid, rsp_addr, rsp_rdata, rsp_err,
           spi_start, spi_tx_data
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           spi_complete, spi_rx_data, spi_rx_valid,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_rdata, rsp_err,
           spi_start, spi_tx_data
  );
endinterface

// File: rtl/host_spi_cmd_seq.sv
// host_spi_cmd_seq
// Host-side register command sequencer in front of host_spi. Commands are
// queued in a small FIFO, each one is turned into a host_spi frame
// {op[1:0], addr, 1'b0, data}, launched with a one-cycle start pulse, and
// waited on under a watchdog. Reads return data (or an error on timeout)
// on the response channel. A fixed idle gap separates consecutive frames.
//
// Ports:
//   clk, rst     : single clock, asynchronous active-high reset
//   bus (slave)  : command / response / host_spi signals, see the interface
//   busy         : state not IDLE or commands still queued
//   err_timeout  : sticky, set by any watchdog expiry, cleared by rst only
//   fifo_level   : number of queued commands
//   dbg_state_o  : current FSM state encoding
module host_spi_cmd_seq #(
  parameter int DATA_W      = 18,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int GAP_CYC     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  host_spi_cmd_seq_if.slave      bus,
  output logic                   busy,
  output logic                   err_timeout,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [2:0]             dbg_state_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = DATA_W + ADDR_W + 3;
  localparam int EW = DATA_W + ADDR_W + 1;   // FIFO entry {write, addr, wdata}
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT_WR = 3'd2,
    S_WAIT_RD = 3'd3,
    S_RESP    = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic              push;
  logic              pop;
  logic [EW-1:0]     head;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  // ------------------------------------------------------------ sequencer
  state_t            state_q, state_d;
  logic [FW-1:0]     tx_q, tx_d;
  logic              start_q, start_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              err_to_q, err_to_d;
  logic [TW-1:0]     wd_q, wd_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              cur_write_q, cur_write_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              wd_expired;

  assign bus.cmd_ready = (count_q != CW'(DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  // The FIFO is drained only by the IDLE -> LAUNCH step; no bypass path.
  assign pop           = (state_q == S_IDLE) && (count_q != '0);

  assign head       = mem_q[rd_ptr_q];
  assign head_write = head[EW-1];
  assign head_addr  = head[EW-2 -: ADDR_W];
  assign head_wdata = head[DATA_W-1:0];

  // Last wait cycle before giving up on host_spi.
  assign wd_expired = (wd_q == TW'(TIMEOUT_CYC - 1));

  // Storage has no reset: the pointers/count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    start_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_to_d    = err_to_q;
    wd_d        = wd_q;
    gap_d       = gap_q;
    cur_write_d = cur_write_q;
    cur_addr_d  = cur_addr_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d     = S_LAUNCH;
          start_d     = 1'b1;   // registered, so high exactly in LAUNCH
          cur_write_d = head_write;
          cur_addr_d  = head_addr;
          tx_d        = {head_write ? 2'b10 : 2'b01, head_addr, 1'b0,
                         head_write ? head_wdata : {DATA_W{1'b0}}};
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        gap_d   = '0;
        state_d = cur_write_q ? S_WAIT_WR : S_WAIT_RD;
      end
      S_WAIT_WR: begin
        // Completion is tested first so it wins over a coincident expiry.
        if (bus.spi_complete) begin
          state_d = S_GAP;
        end else if (wd_expired) begin
          err_to_d = 1'b1;
          state_d  = S_GAP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_WAIT_RD: begin
        if (bus.spi_rx_valid) begin
          rsp_valid_d = 1'b1;
          rsp_addr_d  = cur_addr_q;
          rsp_rdata_d = bus.spi_rx_data;
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end else if (wd_expired) begin
          err_to_d    = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_addr_d  = cur_addr_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      tx_q        <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_to_q    <= 1'b0;
      wd_q        <= '0;
      gap_q       <= '0;
      cur_write_q <= 1'b0;
      cur_addr_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      tx_q        <= tx_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_to_q    <= err_to_d;
      wd_q        <= wd_d;
      gap_q       <= gap_d;
      cur_write_q <= cur_write_d;
      cur_addr_q  <= cur_addr_d;
    end
  end

  assign bus.spi_start   = start_q;
  assign bus.spi_tx_data = tx_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_addr    = rsp_addr_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign busy            = (state_q != S_IDLE) || (count_q != '0);
  assign err_timeout     = err_to_q;
  assign fifo_level      = count_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_host_spi_cmd_seq.sv
// tb_host_spi_cmd_seq
// Drives host_spi_cmd_seq with directed and randomized commands while acting
// as the host_spi engine. A transaction-level model predicts every frame,
// its launch cycle, read responses, FIFO level, busy and the timeout flag.
module tb_host_spi_cmd_seq;

  localparam int DW    = 18;
  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 16;
  localparam int GAP   = 2;
  localparam int FW    = DW + AW + 3;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  host_spi_cmd_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  logic          busy;
  logic          err_timeout;
  logic [LW-1:0] fifo_level;
  logic [2:0]    dbg_state;

  host_spi_cmd_seq #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err_timeout(err_timeout),
    .fifo_level(fifo_level), .dbg_state_o(dbg_state)
  );

  // A command plus how the host_spi model and response consumer treat it:
  // d = wait cycle in which completion/rx_valid is given (d > TO: never),
  // stall = cycles rsp_ready is held low once the response is up.
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            d;
    int            stall;
    int            push_edge;
  } cmd_t;

  cmd_t          stim_q[$];
  cmd_t          meta_q[$];
  logic [FW-1:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bit            act, to_model, pend_v, offering, full_seen;
  cmd_t          cur, pend;
  int            e0, h_edge, done_edge, next_ok;
  logic [FW-1:0] last_frame;
  logic [DW-1:0] exp_rdata;
  logic          exp_err;
  int            p_valid, p_noise;

  // ----------------------------------------------------------- checking
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [FW-1:0] make_frame(input cmd_t c);
    if (c.wr) return {2'b10, c.addr, 1'b0, c.wdata};
    return {2'b01, c.addr, 1'b0, {DW{1'b0}}};
  endfunction

  function automatic cmd_t mk_cmd(input logic wr, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                                  input int d, input int stall);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wdata; c.rdata = rdata;
    c.d = d; c.stall = stall; c.push_edge = 0;
    return c;
  endfunction

  function automatic cmd_t rand_cmd(input int p_hang);
    int d;
    if ($urandom_range(0, 99) < p_hang) d = TO + 1;
    else if ($urandom_range(0, 7) == 0) d = TO;
    else d = $urandom_range(1, TO);
    return mk_cmd(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                  d, $urandom_range(0, 4));
  endfunction

  task automatic check_reset_vals();
    check("rst_spi_start", bus.spi_start, 0);
    check("rst_tx_data", bus.spi_tx_data, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_addr", bus.rsp_addr, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
  endtask

  task automatic model_reset();
    stim_q.delete(); meta_q.delete(); exp_q.delete();
    act = 0; to_model = 0; pend_v = 0; offering = 0;
    last_frame = '0; next_ok = 0;
  endtask

  // One clock: update the model, compare, then drive the next cycle's inputs.
  task automatic tick();
    bit exp_rv, exp_s;
    int due;
    @(posedge clk); #1;
    cyc++;

    if (pend_v) begin
      pend.push_edge = cyc;
      exp_q.push_back(make_frame(pend));
      meta_q.push_back(pend);
      pend_v = 0;
    end
    if (act && cur.d > TO && cyc == h_edge) to_model = 1;
    if (act && cyc == done_edge) begin
      act = 0;
      next_ok = done_edge + GAP + 1;
    end

    if (bus.spi_start && !act && exp_q.size() != 0) begin
      check("start_edge", cyc, imax(next_ok, meta_q[0].push_edge + 1));
      check("frame", bus.spi_tx_data, exp_q[0]);
      last_frame = exp_q.pop_front();
      cur = meta_q.pop_front();
      act = 1;
      e0 = cyc;
      h_edge = (cur.d > TO) ? e0 + TO + 1 : e0 + cur.d + 1;
      done_edge = cur.wr ? h_edge : h_edge + cur.stall + 1;
      exp_rdata = (cur.d > TO) ? '0 : cur.rdata;
      exp_err = (cur.d > TO);
    end else begin
      due = (exp_q.size() != 0) ? imax(next_ok, meta_q[0].push_edge + 1) : 0;
      exp_s = !act && exp_q.size() != 0 && cyc >= due;
      check("spi_start", bus.spi_start, exp_s);
    end

    exp_rv = act && !cur.wr && cyc >= h_edge && cyc <= h_edge + cur.stall;
    check("rsp_valid", bus.rsp_valid, exp_rv);
    if (exp_rv) begin
      check("rsp_addr", bus.rsp_addr, cur.addr);
      check("rsp_rdata", bus.rsp_rdata, exp_rdata);
      check("rsp_err", bus.rsp_err, exp_err);
    end
    check("tx_hold", bus.spi_tx_data, last_frame);
    check("fifo_level", fifo_level, exp_q.size());
    check("cmd_ready", bus.cmd_ready, exp_q.size() < DEPTH);
    check("busy", busy, act || exp_q.size() != 0 || cyc < next_ok - 1);
    check("err_timeout", err_timeout, to_model);

    // host_spi model: answer in wait cycle d; stray pulses elsewhere.
    bus.spi_complete = 1'b0;
    bus.spi_rx_valid = 1'b0;
    bus.spi_rx_data  = DW'($urandom);
    if (act && cyc >= e0 + 1 && cyc < h_edge) begin
      if (cyc == e0 + cur.d) begin
        if (cur.wr) bus.spi_complete = 1'b1;
        else begin bus.spi_rx_valid = 1'b1; bus.spi_rx_data = cur.rdata; end
      end else if ($urandom_range(0, 99) < p_noise) begin
        if (cur.wr) bus.spi_rx_valid = 1'b1;
        else bus.spi_complete = 1'b1;
      end
    end else begin
      bus.spi_complete = ($urandom_range(0, 99) < p_noise);
      bus.spi_rx_valid = ($urandom_range(0, 99) < p_noise);
    end

    // Response consumer
    if (act && !cur.wr && cyc >= h_edge && cyc <= h_edge + cur.stall)
      bus.rsp_ready = (cyc == h_edge + cur.stall);
    else
      bus.rsp_ready = 1'($urandom);

    // Host: once offered, a command stays offered until accepted.
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_wdata = DW'($urandom);
    if (stim_q.size() != 0 && (offering || $urandom_range(0, 99) < p_valid)) begin
      offering = 1;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = stim_q[0].wr;
      bus.cmd_addr  = stim_q[0].addr;
      bus.cmd_wdata = stim_q[0].wdata;
      if (bus.cmd_ready) begin
        pend = stim_q.pop_front();
        pend_v = 1;
        offering = 0;
      end else begin
        full_seen = 1;
      end
    end
  endtask

  task automatic drain(input int max_cyc);
    bit ok;
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (stim_q.size() == 0 && !pend_v && exp_q.size() == 0 && !act && cyc >= next_ok) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("drain", ok, 1);
  endtask

  task automatic zero_inputs();
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0; bus.spi_complete = 1'b0; bus.spi_rx_valid = 1'b0;
    bus.spi_rx_data = '0;
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    bit ok;
    zero_inputs();
    model_reset();
    p_valid = 100;
    p_noise = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;
    cyc = 0;

    // Single write, then single stalled read with a write queued behind it.
    stim_q.push_back(mk_cmd(1'b1, 8'h00, 18'h10101, '0, 3, 0));
    drain(200);
    stim_q.push_back(mk_cmd(1'b0, 8'h03, '0, 18'h2ABCD, 4, 10));
    stim_q.push_back(mk_cmd(1'b1, 8'h21, 18'h0F0F0, '0, 2, 0));
    drain(200);

    // Fill the FIFO behind a slow write whose completion lands on the
    // watchdog terminal count.
    full_seen = 0;
    stim_q.push_back(mk_cmd(1'b1, 8'h40, 18'h3C3C3, '0, TO, 0));
    for (int i = 0; i < 5; i++) stim_q.push_back(rand_cmd(0));
    drain(600);
    check("full_seen", full_seen, 1);

    // Read with no answer at all, then a normal write.
    stim_q.push_back(mk_cmd(1'b0, 8'h07, '0, 18'h3FFFF, TO + 1, 2));
    stim_q.push_back(mk_cmd(1'b1, 8'h08, 18'h12345, '0, 2, 0));
    drain(300);

    // Stray host_spi pulses while idle.
    p_noise = 40;
    repeat (20) tick();

    // Random batches at different offered loads.
    for (int b = 0; b < 3; b++) begin
      p_valid = (b == 0) ? 100 : (b == 1) ? 50 : 15;
      for (int i = 0; i < 20; i++) stim_q.push_back(rand_cmd(10));
      drain(3000);
    end

    // Reset while a read waits and two commands are queued.
    p_valid = 100;
    p_noise = 0;
    stim_q.push_back(mk_cmd(1'b0, 8'h55, '0, 18'h11111, TO + 1, 0));
    stim_q.push_back(mk_cmd(1'b1, 8'h56, 18'h22222, '0, 2, 0));
    stim_q.push_back(mk_cmd(1'b1, 8'h57, 18'h33333, '0, 2, 0));
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (act && !cur.wr && cyc >= e0 + 3 && exp_q.size() == 2) begin
        ok = 1;
        break;
      end
    end
    check("rst_setup", ok, 1);
    zero_inputs();
    #2 rst = 1'b1;
    #1;
    check_reset_vals();
    model_reset();
    repeat (2) begin @(posedge clk); cyc++; end
    #1 rst = 1'b0;
    p_noise = 20;
    repeat (30) tick();

    // Recovery after reset.
    for (int i = 0; i < 6; i++) stim_q.push_back(rand_cmd(0));
    drain(600);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
